// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: configuration shadowing and frame buffering for a UART receiver.
// Host config writes are held in a shadow and applied only between frames.
// Completed frames and their error flags go into a small fall-through FIFO,
// alongside sticky overrun and a saturating error counter.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH       = 8,
  parameter int FIFO_DEPTH       = 4,
  parameter int PRESCALE_DEFAULT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_wr,
  input  logic [4:0]            cfg_prescale,
  input  logic                  cfg_par_en,
  input  logic                  cfg_par_typ,
  input  logic                  cfg_rx_en,
  input  logic                  rx_busy,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_data_valid,
  input  logic                  rx_par_err,
  input  logic                  rx_stp_err,
  output logic [4:0]            rx_prescale,
  output logic                  rx_par_en,
  output logic                  rx_par_typ,
  output logic                  rx_enable,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [1:0]            rd_err,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic                  overrun,
  input  logic                  clr_status,
  output logic [7:0]            err_cnt,
  output logic                  cfg_pending
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = DATA_WIDTH + 2;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_BUSY  = 2'd2,
    ST_APPLY = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Shadow (requested) configuration
  logic [4:0] sh_prescale_q;
  logic       sh_par_en_q;
  logic       sh_par_typ_q;
  logic       sh_rx_en_q;
  logic       pending_q, pending_d;

  // Active configuration driven to the receiver
  logic [4:0] act_prescale_q;
  logic       act_par_en_q;
  logic       act_par_typ_q;

  // FIFO pointers carry one extra wrap bit to tell full from empty
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [EW-1:0] mem_rd [FIFO_DEPTH];
  logic [EW-1:0] head;
  logic          empty, full;
  logic          push, pop, drop;
  logic          count_err;

  logic       overrun_q, overrun_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  // Shadow registers capture every host write, including one during APPLY
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_prescale_q <= 5'(PRESCALE_DEFAULT);
      sh_par_en_q   <= 1'b0;
      sh_par_typ_q  <= 1'b0;
      sh_rx_en_q    <= 1'b0;
    end else if (cfg_wr) begin
      sh_prescale_q <= cfg_prescale;
      sh_par_en_q   <= cfg_par_en;
      sh_par_typ_q  <= cfg_par_typ;
      sh_rx_en_q    <= cfg_rx_en;
    end
  end

  // Pending flag: a write always re-arms it, even one landing in APPLY
  always_comb begin
    pending_d = pending_q;
    if (cfg_wr) begin
      pending_d = 1'b1;
    end else if (state_q == ST_APPLY) begin
      pending_d = 1'b0;
    end
  end

  // State, pending flag and active config registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_OFF;
      pending_q      <= 1'b0;
      act_prescale_q <= 5'(PRESCALE_DEFAULT);
      act_par_en_q   <= 1'b0;
      act_par_typ_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      // APPLY copies the shadow as it stood before any same-cycle write
      if (state_q == ST_APPLY) begin
        act_prescale_q <= sh_prescale_q;
        act_par_en_q   <= sh_par_en_q;
        act_par_typ_q  <= sh_par_typ_q;
      end
    end
  end

  // Next-state logic; a starting frame takes priority over a pending apply
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF: begin
        if (pending_q) state_d = ST_APPLY;
      end
      ST_IDLE: begin
        if (rx_busy)        state_d = ST_BUSY;
        else if (pending_q) state_d = ST_APPLY;
      end
      ST_BUSY: begin
        // Completed frame or aborted frame both end the busy window
        if (rx_data_valid || !rx_busy) state_d = ST_IDLE;
      end
      ST_APPLY: begin
        state_d = sh_rx_en_q ? ST_IDLE : ST_OFF;
      end
      default: state_d = ST_OFF;
    endcase
  end

  assign rx_enable   = (state_q == ST_IDLE) || (state_q == ST_BUSY);
  assign rx_prescale = act_prescale_q;
  assign rx_par_en   = act_par_en_q;
  assign rx_par_typ  = act_par_typ_q;
  assign cfg_pending = pending_q;

  // FIFO control: a pop frees the slot a simultaneous push needs when full
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop       = rd_en && !empty;
  assign push      = rx_data_valid && (!full || pop);
  assign drop      = rx_data_valid && full && !pop;
  assign count_err = push && (rx_par_err || rx_stp_err);

  // Storage entries, one register per slot, written only when addressed
  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
    logic [EW-1:0] entry_q;

    // Slot write; contents need no reset since pointers gate visibility
    always_ff @(posedge clk) begin
      if (push && (wr_ptr_q[AW-1:0] == AW'(gi))) begin
        entry_q <= {rx_stp_err, rx_par_err, rx_data};
      end
    end

    assign mem_rd[gi] = entry_q;
  end

  assign head       = mem_rd[rd_ptr_q[AW-1:0]];
  assign rd_data    = head[DATA_WIDTH-1:0];
  assign rd_err     = head[EW-1:DATA_WIDTH];
  assign fifo_empty = empty;
  assign fifo_full  = full;

  // FIFO pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Status next-state: a new event in the clearing cycle survives the clear
  always_comb begin
    overrun_d = overrun_q;
    err_cnt_d = err_cnt_q;
    if (drop)            overrun_d = 1'b1;
    else if (clr_status) overrun_d = 1'b0;

    if (count_err) begin
      if (clr_status)              err_cnt_d = 8'd1;
      else if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end else if (clr_status) begin
      err_cnt_d = 8'd0;
    end
  end

  // Status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_q <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      overrun_q <= overrun_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign overrun = overrun_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: config apply sequencing, FIFO
// fill/drain/overrun, error counting, and asynchronous reset.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_wr;
  logic [4:0] cfg_prescale;
  logic       cfg_par_en, cfg_par_typ, cfg_rx_en;
  logic       rx_busy;
  logic [7:0] rx_data;
  logic       rx_data_valid, rx_par_err, rx_stp_err;
  logic [4:0] rx_prescale;
  logic       rx_par_en, rx_par_typ, rx_enable;
  logic       rd_en;
  logic [7:0] rd_data;
  logic [1:0] rd_err;
  logic       fifo_empty, fifo_full, overrun;
  logic       clr_status;
  logic [7:0] err_cnt;
  logic       cfg_pending;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       par;
    logic       stp;
    logic       rd;
    logic       clr;
    logic       exp_empty;
    logic       exp_full;
    logic [7:0] exp_head;
    logic [1:0] exp_err;
    logic       exp_ov;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  uart_rx_ctrl #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .PRESCALE_DEFAULT(8)) dut (
    .clk(clk), .rst(rst),
    .cfg_wr(cfg_wr), .cfg_prescale(cfg_prescale), .cfg_par_en(cfg_par_en),
    .cfg_par_typ(cfg_par_typ), .cfg_rx_en(cfg_rx_en),
    .rx_busy(rx_busy), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .rx_par_err(rx_par_err), .rx_stp_err(rx_stp_err),
    .rx_prescale(rx_prescale), .rx_par_en(rx_par_en), .rx_par_typ(rx_par_typ),
    .rx_enable(rx_enable),
    .rd_en(rd_en), .rd_data(rd_data), .rd_err(rd_err),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full), .overrun(overrun),
    .clr_status(clr_status), .err_cnt(err_cnt), .cfg_pending(cfg_pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [4:0] p, input logic pe, input logic pt, input logic en);
    cfg_wr = 1'b1; cfg_prescale = p; cfg_par_en = pe; cfg_par_typ = pt; cfg_rx_en = en;
  endtask

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic par,
                              input logic stp, input logic rd, input logic clr,
                              input logic e, input logic f, input logic [7:0] h,
                              input logic [1:0] er, input logic ov, input logic [7:0] c);
    vec_t t;
    t.v = v; t.d = d; t.par = par; t.stp = stp; t.rd = rd; t.clr = clr;
    t.exp_empty = e; t.exp_full = f; t.exp_head = h; t.exp_err = er;
    t.exp_ov = ov; t.exp_cnt = c;
    return t;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, " prescale"}, 32'(rx_prescale), 32'd8);
    check({tag, " par_en"},   32'(rx_par_en), 32'd0);
    check({tag, " par_typ"},  32'(rx_par_typ), 32'd0);
    check({tag, " enable"},   32'(rx_enable), 32'd0);
    check({tag, " empty"},    32'(fifo_empty), 32'd1);
    check({tag, " full"},     32'(fifo_full), 32'd0);
    check({tag, " overrun"},  32'(overrun), 32'd0);
    check({tag, " err_cnt"},  32'(err_cnt), 32'd0);
    check({tag, " pending"},  32'(cfg_pending), 32'd0);
  endtask

  initial begin
    rst = 1'b1; cfg_wr = 0; cfg_prescale = 0; cfg_par_en = 0; cfg_par_typ = 0;
    cfg_rx_en = 0; rx_busy = 0; rx_data = 0; rx_data_valid = 0; rx_par_err = 0;
    rx_stp_err = 0; rd_en = 0; clr_status = 0;

    // Vector table: inputs applied for one edge, outputs checked just after.
    //        v  d      par stp rd clr | empty full head   err  ov cnt
    vecs.push_back(mk(1, 8'h01, 0, 0, 0, 0,  0, 0, 8'h01, 2'b00, 0, 8'd0));
    vecs.push_back(mk(1, 8'h02, 0, 0, 0, 0,  0, 0, 8'h01, 2'b00, 0, 8'd0));
    vecs.push_back(mk(1, 8'h03, 0, 0, 0, 0,  0, 0, 8'h01, 2'b00, 0, 8'd0));
    vecs.push_back(mk(1, 8'h04, 0, 0, 0, 0,  0, 1, 8'h01, 2'b00, 0, 8'd0));
    vecs.push_back(mk(1, 8'h05, 0, 0, 0, 0,  0, 1, 8'h01, 2'b00, 1, 8'd0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0,  0, 0, 8'h02, 2'b00, 1, 8'd0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0,  0, 0, 8'h03, 2'b00, 1, 8'd0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0,  0, 0, 8'h04, 2'b00, 1, 8'd0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0,  1, 0, 8'h00, 2'b00, 1, 8'd0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1,  1, 0, 8'h00, 2'b00, 0, 8'd0));
    vecs.push_back(mk(1, 8'h11, 0, 0, 0, 0,  0, 0, 8'h11, 2'b00, 0, 8'd0));
    vecs.push_back(mk(1, 8'h22, 0, 0, 0, 0,  0, 0, 8'h11, 2'b00, 0, 8'd0));
    vecs.push_back(mk(1, 8'h33, 0, 0, 0, 0,  0, 0, 8'h11, 2'b00, 0, 8'd0));
    vecs.push_back(mk(1, 8'h44, 0, 0, 0, 0,  0, 1, 8'h11, 2'b00, 0, 8'd0));
    vecs.push_back(mk(1, 8'h66, 0, 0, 1, 0,  0, 1, 8'h22, 2'b00, 0, 8'd0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0,  0, 0, 8'h33, 2'b00, 0, 8'd0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0,  0, 0, 8'h44, 2'b00, 0, 8'd0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0,  0, 0, 8'h66, 2'b00, 0, 8'd0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0,  1, 0, 8'h00, 2'b00, 0, 8'd0));
    vecs.push_back(mk(1, 8'h5A, 1, 0, 0, 0,  0, 0, 8'h5A, 2'b01, 0, 8'd1));
    vecs.push_back(mk(1, 8'hC3, 0, 1, 0, 0,  0, 0, 8'h5A, 2'b01, 0, 8'd2));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0,  0, 0, 8'hC3, 2'b10, 0, 8'd2));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0,  1, 0, 8'h00, 2'b00, 0, 8'd2));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1,  1, 0, 8'h00, 2'b00, 0, 8'd0));
    vecs.push_back(mk(1, 8'h77, 1, 1, 0, 1,  0, 0, 8'h77, 2'b11, 0, 8'd1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0,  1, 0, 8'h00, 2'b00, 0, 8'd1));
    vecs.push_back(mk(1, 8'h88, 0, 0, 0, 0,  0, 0, 8'h88, 2'b00, 0, 8'd1));
    vecs.push_back(mk(1, 8'h99, 0, 0, 1, 0,  0, 0, 8'h99, 2'b00, 0, 8'd1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0,  1, 0, 8'h00, 2'b00, 0, 8'd1));
    vecs.push_back(mk(1, 8'hA0, 0, 0, 0, 0,  0, 0, 8'hA0, 2'b00, 0, 8'd1));
    vecs.push_back(mk(1, 8'hA1, 0, 0, 0, 0,  0, 0, 8'hA0, 2'b00, 0, 8'd1));
    vecs.push_back(mk(1, 8'hA2, 0, 0, 0, 0,  0, 0, 8'hA0, 2'b00, 0, 8'd1));
    vecs.push_back(mk(1, 8'hA3, 0, 0, 0, 0,  0, 1, 8'hA0, 2'b00, 0, 8'd1));
    vecs.push_back(mk(1, 8'hA4, 0, 0, 0, 1,  0, 1, 8'hA0, 2'b00, 1, 8'd0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0,  0, 0, 8'hA1, 2'b00, 1, 8'd0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0,  0, 0, 8'hA2, 2'b00, 1, 8'd0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0,  0, 0, 8'hA3, 2'b00, 1, 8'd0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0,  1, 0, 8'h00, 2'b00, 1, 8'd0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1,  1, 0, 8'h00, 2'b00, 0, 8'd0));

    // Reset state
    step(); step();
    check_reset_values("reset");
    rst = 1'b0;
    step();

    // First config: OFF -> APPLY -> IDLE
    cfg(5'd16, 1, 1, 1);
    step();
    cfg_wr = 0;
    $display("txn cfg_wr prescale=16 par_en=1 typ=1 rx_en=1");
    check("cfg1 pending", 32'(cfg_pending), 32'd1);
    check("cfg1 off enable", 32'(rx_enable), 32'd0);
    check("cfg1 prescale early", 32'(rx_prescale), 32'd8);
    step();  // APPLY cycle
    check("cfg1 apply enable", 32'(rx_enable), 32'd0);
    check("cfg1 apply prescale", 32'(rx_prescale), 32'd8);
    step();  // IDLE
    check("cfg1 prescale", 32'(rx_prescale), 32'd16);
    check("cfg1 par_en", 32'(rx_par_en), 32'd1);
    check("cfg1 par_typ", 32'(rx_par_typ), 32'd1);
    check("cfg1 enable", 32'(rx_enable), 32'd1);
    check("cfg1 pending clr", 32'(cfg_pending), 32'd0);

    // Write during a frame is frozen until the frame completes.
    // The requested prescale of 32 does not fit 5 bits, so 24 stands in.
    rx_busy = 1;
    step();  // BUSY
    cfg(5'd24, 1, 1, 1);
    step();
    cfg_wr = 0;
    $display("txn cfg_wr prescale=24 during frame");
    check("busy pending", 32'(cfg_pending), 32'd1);
    check("busy prescale hold", 32'(rx_prescale), 32'd16);
    check("busy enable", 32'(rx_enable), 32'd1);
    step(); step();
    check("busy prescale hold2", 32'(rx_prescale), 32'd16);
    rx_data = 8'hA5; rx_data_valid = 1;
    step();  // IDLE, A5 stored
    rx_data_valid = 0; rx_busy = 0;
    $display("txn frame 0xA5");
    check("a5 empty", 32'(fifo_empty), 32'd0);
    check("a5 data", 32'(rd_data), 32'hA5);
    check("a5 err", 32'(rd_err), 32'd0);
    check("a5 prescale", 32'(rx_prescale), 32'd16);
    step();  // APPLY
    check("cfg2 apply enable", 32'(rx_enable), 32'd0);
    check("cfg2 apply prescale", 32'(rx_prescale), 32'd16);
    step();
    check("cfg2 prescale", 32'(rx_prescale), 32'd24);
    check("cfg2 enable", 32'(rx_enable), 32'd1);
    check("cfg2 pending", 32'(cfg_pending), 32'd0);
    rd_en = 1;
    step();
    rd_en = 0;
    check("a5 popped", 32'(fifo_empty), 32'd1);

    // Table-driven FIFO and status vectors
    for (int i = 0; i < vecs.size(); i++) begin
      rx_data_valid = vecs[i].v; rx_data = vecs[i].d;
      rx_par_err = vecs[i].par; rx_stp_err = vecs[i].stp;
      rd_en = vecs[i].rd; clr_status = vecs[i].clr;
      step();
      $display("txn vec %0d v=%0d d=%02h rd=%0d clr=%0d", i, vecs[i].v, vecs[i].d,
               vecs[i].rd, vecs[i].clr);
      check($sformatf("vec%0d empty", i), 32'(fifo_empty), 32'(vecs[i].exp_empty));
      check($sformatf("vec%0d full", i), 32'(fifo_full), 32'(vecs[i].exp_full));
      check($sformatf("vec%0d overrun", i), 32'(overrun), 32'(vecs[i].exp_ov));
      check($sformatf("vec%0d err_cnt", i), 32'(err_cnt), 32'(vecs[i].exp_cnt));
      if (!vecs[i].exp_empty) begin
        check($sformatf("vec%0d head", i), 32'(rd_data), 32'(vecs[i].exp_head));
        check($sformatf("vec%0d rd_err", i), 32'(rd_err), 32'(vecs[i].exp_err));
      end
    end
    rx_data_valid = 0; rx_data = 0; rx_par_err = 0; rx_stp_err = 0;
    rd_en = 0; clr_status = 0;

    // Error counter saturation: 260 errored frames, each pushed with a pop
    for (int i = 0; i < 260; i++) begin
      rx_data_valid = 1; rx_data = 8'(i); rx_par_err = 1; rd_en = 1;
      step();
      if (i == 253) check("sat 254", 32'(err_cnt), 32'd254);
    end
    rx_data_valid = 0; rx_par_err = 0;
    $display("txn 260 errored frames");
    check("sat 255", 32'(err_cnt), 32'd255);
    check("sat no overrun", 32'(overrun), 32'd0);
    step();  // pops the one remaining entry
    rd_en = 0;
    check("sat drained", 32'(fifo_empty), 32'd1);
    clr_status = 1;
    step();
    clr_status = 0;
    check("sat clr", 32'(err_cnt), 32'd0);

    // Aborted frame: nothing stored, and the FSM must accept an apply after
    rx_busy = 1;
    step();
    rx_busy = 0;
    step();
    $display("txn aborted frame");
    check("abort empty", 32'(fifo_empty), 32'd1);
    check("abort enable", 32'(rx_enable), 32'd1);
    cfg(5'd5, 0, 0, 0);
    step();
    cfg_wr = 0;
    $display("txn cfg_wr rx_en=0");
    check("off pending", 32'(cfg_pending), 32'd1);
    step();  // APPLY (only reachable from IDLE, not BUSY)
    check("off apply enable", 32'(rx_enable), 32'd0);
    check("off apply prescale", 32'(rx_prescale), 32'd24);
    step();  // OFF
    check("off prescale", 32'(rx_prescale), 32'd5);
    check("off par_en", 32'(rx_par_en), 32'd0);
    check("off pending clr", 32'(cfg_pending), 32'd0);
    step();
    check("off enable", 32'(rx_enable), 32'd0);

    // Write landing in the APPLY cycle triggers a second apply pass
    cfg(5'd10, 1, 0, 1);
    step();
    cfg_wr = 0;
    step();  // APPLY of 10
    cfg(5'd12, 0, 1, 1);
    step();  // IDLE, old shadow applied, new one pending
    cfg_wr = 0;
    $display("txn cfg_wr during APPLY");
    check("dbl prescale1", 32'(rx_prescale), 32'd10);
    check("dbl par_en1", 32'(rx_par_en), 32'd1);
    check("dbl typ1", 32'(rx_par_typ), 32'd0);
    check("dbl pending", 32'(cfg_pending), 32'd1);
    check("dbl enable1", 32'(rx_enable), 32'd1);
    step();  // second APPLY
    check("dbl apply enable", 32'(rx_enable), 32'd0);
    step();
    check("dbl prescale2", 32'(rx_prescale), 32'd12);
    check("dbl par_en2", 32'(rx_par_en), 32'd0);
    check("dbl typ2", 32'(rx_par_typ), 32'd1);
    check("dbl pending clr", 32'(cfg_pending), 32'd0);
    check("dbl enable2", 32'(rx_enable), 32'd1);

    // Asynchronous reset in the middle of a frame with state outstanding
    rx_data = 8'h42; rx_data_valid = 1; rx_stp_err = 1;
    step();
    rx_data_valid = 0; rx_stp_err = 0;
    check("pre-rst empty", 32'(fifo_empty), 32'd0);
    check("pre-rst err_cnt", 32'(err_cnt), 32'd1);
    rx_busy = 1;
    step();  // BUSY
    cfg(5'd3, 1, 1, 1);
    step();
    cfg_wr = 0;
    check("pre-rst pending", 32'(cfg_pending), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    $display("txn async reset mid-frame");
    check_reset_values("async rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
